// File: rtl/fwd_ctrl_unit.sv
// rtl/fwd_ctrl_unit.sv - ALU operand forwarding select and load-use stall generator for the mips32 pipeline.
// Optional stall/forward statistics counters are enabled by defining FWD_CTRL_STATS_EN.
module fwd_ctrl_unit #(
  parameter int REG_W = 5,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_valid,
  input  logic             flush,
  input  logic             ext_stall,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
`ifdef FWD_CTRL_STATS_EN
  output logic [31:0]      stall_cnt,
  output logic [31:0]      fwd_cnt,
`endif
  output logic             stall
);

  localparam logic [SEL_W-1:0] SEL_RF    = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_EXMEM = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_MEMWB = SEL_W'(2);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } stage_rec_t;

  typedef struct packed {
    stage_rec_t       st;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
  } ex_rec_t;

  ex_rec_t          ex_q, ex_d;
  stage_rec_t       mem_q, wb_q;
  logic [SEL_W-1:0] fwd_a_sel_q, fwd_b_sel_q;
  logic [SEL_W-1:0] fwd_a_sel_d, fwd_b_sel_d;
  logic             load_hit;
  logic             bubble;

  // The EX record is the producer about to enter MEM; it outranks the MEM record.
  function automatic logic [SEL_W-1:0] pick_sel(
    input logic             u,
    input logic [REG_W-1:0] r,
    input stage_rec_t       ex,
    input stage_rec_t       mem
  );
    logic [SEL_W-1:0] sel;
    sel = SEL_RF;
    if (u && ex.valid && ex.reg_write && ex.rd != '0 && ex.rd == r)
      sel = SEL_EXMEM;
    else if (u && mem.valid && mem.reg_write && mem.rd != '0 && mem.rd == r)
      sel = SEL_MEMWB;
    return sel;
  endfunction

  always_comb begin
    load_hit = ex_q.st.valid && ex_q.st.mem_read && ex_q.st.reg_write &&
               (ex_q.st.rd != '0) && id_valid &&
               ((id_use_rs && id_rs == ex_q.st.rd) || (id_use_rt && id_rt == ex_q.st.rd));
    stall    = load_hit && !flush;
    bubble   = flush || stall;
  end

  always_comb begin
    fwd_a_sel_d     = pick_sel(id_use_rs, id_rs, ex_q.st, mem_q);
    fwd_b_sel_d     = pick_sel(id_use_rt, id_rt, ex_q.st, mem_q);
    ex_d            = '0;
    ex_d.st.valid     = id_valid;
    ex_d.st.rd        = id_rd;
    ex_d.st.reg_write = id_reg_write;
    ex_d.st.mem_read  = id_mem_read;
    ex_d.rs           = id_rs;
    ex_d.rt           = id_rt;
    ex_d.use_rs       = id_use_rs;
    ex_d.use_rt       = id_use_rt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_sel_q <= SEL_RF;
      fwd_b_sel_q <= SEL_RF;
    end else if (!ext_stall) begin
      wb_q  <= mem_q;
      mem_q <= ex_q.st;
      if (bubble) begin
        ex_q        <= '0;
        fwd_a_sel_q <= SEL_RF;
        fwd_b_sel_q <= SEL_RF;
      end else begin
        ex_q        <= ex_d;
        fwd_a_sel_q <= fwd_a_sel_d;
        fwd_b_sel_q <= fwd_b_sel_d;
      end
    end
  end

  assign fwd_a_sel = fwd_a_sel_q;
  assign fwd_b_sel = fwd_b_sel_q;

`ifdef FWD_CTRL_STATS_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!ext_stall) begin
      if (stall)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!bubble && (fwd_a_sel_d != SEL_RF || fwd_b_sel_d != SEL_RF))
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

  // Source fields of EX and the WB record are kept for debug visibility only.
  logic unused_rec;
  assign unused_rec = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// tb/tb_fwd_ctrl_unit.sv - directed and randomized checks of fwd_ctrl_unit against an instruction-list pipeline model.
module tb_fwd_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_use_rs = 0, id_use_rt = 0, id_reg_write = 0, id_mem_read = 0, id_valid = 0;
  logic       flush = 0, ext_stall = 0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall;

  fwd_ctrl_unit dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_valid(id_valid),
    .flush(flush), .ext_stall(ext_stall),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [4:0] rd, rs, rt;
    bit       wr, ld, urs, urt;
  } ins_t;

  ins_t pipe[3];          // [0]=EX, [1]=MEM, [2]=WB
  int   exp_a, exp_b;
  int   n_vec = 0, n_err = 0;
  bit   seen_stall;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Youngest matching writer among the producers ahead of ID; code = 1 + distance.
  function automatic int ref_sel(input bit u, input bit [4:0] r);
    for (int k = 0; k < 2; k++)
      if (u && pipe[k].v && pipe[k].wr && pipe[k].rd != 0 && pipe[k].rd == r)
        return k + 1;
    return 0;
  endfunction

  task automatic step(input bit r, input bit ext, input bit fl, input ins_t i);
    bit   exp_stall;
    ins_t bub;
    int   na, nb;
    rst = r; ext_stall = ext; flush = fl;
    id_valid = i.v; id_rd = i.rd; id_rs = i.rs; id_rt = i.rt;
    id_reg_write = i.wr; id_mem_read = i.ld; id_use_rs = i.urs; id_use_rt = i.urt;
    @(negedge clk);
    exp_stall = !fl && i.v && pipe[0].v && pipe[0].ld && pipe[0].wr && pipe[0].rd != 0 &&
                ((i.urs && i.rs == pipe[0].rd) || (i.urt && i.rt == pipe[0].rd));
    seen_stall = stall;
    chk("stall", int'(stall), int'(exp_stall));
    na = ref_sel(i.urs, i.rs);
    nb = ref_sel(i.urt, i.rt);
    @(posedge clk);
    #1;
    bub = '{default: 0};
    if (r) begin
      pipe[0] = bub; pipe[1] = bub; pipe[2] = bub; exp_a = 0; exp_b = 0;
    end else if (!ext) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (fl || exp_stall) begin
        pipe[0] = bub; exp_a = 0; exp_b = 0;
      end else begin
        pipe[0] = i; exp_a = na; exp_b = nb;
      end
    end
    chk("fwd_a_sel", int'(fwd_a_sel), exp_a);
    chk("fwd_b_sel", int'(fwd_b_sel), exp_b);
  endtask

  function automatic ins_t mk(input bit [4:0] rd, input bit wr, input bit ld,
                              input bit [4:0] rs, input bit urs, input bit [4:0] rt, input bit urt);
    ins_t i;
    i.v = 1; i.rd = rd; i.wr = wr; i.ld = ld; i.rs = rs; i.urs = urs; i.rt = rt; i.urt = urt;
    return i;
  endfunction

  ins_t nop, rnd;

  initial begin
    nop = '{default: 0};
    pipe[0] = nop; pipe[1] = nop; pipe[2] = nop; exp_a = 0; exp_b = 0;

    step(1, 0, 0, nop);
    chk("reset_a", int'(fwd_a_sel), 0);
    chk("reset_stall", int'(seen_stall), 0);

    // add r3 ; sub rs=r3
    step(0, 0, 0, mk(3, 1, 0, 1, 1, 2, 1));
    step(0, 0, 0, mk(6, 1, 0, 3, 1, 4, 1));
    chk("tp1_a", int'(fwd_a_sel), 1);
    chk("tp1_b", int'(fwd_b_sel), 0);

    // add r3 ; nop ; or rt=r3
    step(0, 0, 0, mk(3, 1, 0, 1, 1, 2, 1));
    step(0, 0, 0, nop);
    step(0, 0, 0, mk(7, 1, 0, 8, 1, 3, 1));
    chk("tp2_b", int'(fwd_b_sel), 2);

    // add r3 ; add r3 ; user rs=r3
    step(0, 0, 0, mk(3, 1, 0, 1, 1, 2, 1));
    step(0, 0, 0, mk(3, 1, 0, 1, 1, 2, 1));
    step(0, 0, 0, mk(9, 1, 0, 3, 1, 0, 0));
    chk("tp3_a", int'(fwd_a_sel), 1);

    // lw r5 ; add rt=r5 held in ID for the stall cycle
    step(0, 0, 0, mk(5, 1, 1, 1, 1, 0, 0));
    step(0, 0, 0, mk(10, 1, 0, 2, 1, 5, 1));
    chk("tp4_stall", int'(seen_stall), 1);
    chk("tp4_bub_b", int'(fwd_b_sel), 0);
    step(0, 0, 0, mk(10, 1, 0, 2, 1, 5, 1));
    chk("tp4_stall_once", int'(seen_stall), 0);
    chk("tp4_b", int'(fwd_b_sel), 2);

    // writer of r0 never forwards nor stalls
    step(0, 0, 0, mk(0, 1, 1, 1, 1, 0, 0));
    step(0, 0, 0, mk(11, 1, 0, 0, 1, 0, 1));
    chk("tp5_stall", int'(seen_stall), 0);
    chk("tp5_a", int'(fwd_a_sel), 0);

    // freeze mid-hazard, then reset with the load in EX
    step(0, 0, 0, mk(3, 1, 0, 1, 1, 0, 0));
    step(0, 0, 0, mk(5, 1, 1, 3, 1, 0, 0));
    chk("tp6_pre_a", int'(fwd_a_sel), 1);
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 0, mk(12, 1, 0, 5, 1, 0, 0));
      chk("tp6_frz_stall", int'(seen_stall), 1);
      chk("tp6_frz_a", int'(fwd_a_sel), 1);
    end
    step(1, 0, 0, mk(12, 1, 0, 5, 1, 0, 0));
    step(0, 0, 0, mk(12, 1, 0, 5, 1, 0, 0));
    chk("tp6_rst_stall", int'(seen_stall), 0);
    chk("tp6_rst_a", int'(fwd_a_sel), 0);

    // random traffic over a small register set to provoke frequent matches
    for (int n = 0; n < 600; n++) begin
      rnd.v   = ($urandom_range(0, 9) != 0);
      rnd.rd  = 5'($urandom_range(0, 3));
      rnd.rs  = 5'($urandom_range(0, 3));
      rnd.rt  = 5'($urandom_range(0, 3));
      rnd.wr  = 1'($urandom);
      rnd.ld  = 1'($urandom);
      rnd.urs = rnd.v & 1'($urandom);
      rnd.urt = rnd.v & 1'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, rnd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
